// File: rtl/membus_rr_arbiter.sv
// membus_rr_arbiter: two-master round-robin arbiter in front of the picorv32-native memory bus.
// A registered grant stage picks the owner, the owner's request is passed through to the slave
// side, and a per-transaction timeout completes a hung access with an error response.
//
// Ports
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_mN_* (N=0,1)          master requests: valid, instr, addr, wdata, wstrb
//   o_mN_ready, o_mN_rdata  per-master completion and read data
//   o_s_*                   request muxed from the granted master to the address decode
//   i_s_ready, i_s_rdata    slave completion and read data
//   o_grant                 one-hot owner (01 = M0, 10 = M1, 00 = idle)
//   o_bus_err               one-cycle pulse on a timeout completion
//   o_err_addr, o_err_master  address / master of the last timed-out transaction
module membus_rr_arbiter #(
   parameter int unsigned TIMEOUT_CYC = 255,
   parameter int unsigned CNT_W       = 8,
   parameter logic [31:0] ERR_RDATA   = 32'hFFFF_FFFF,
   parameter bit          M0_FIRST    = 1'b1
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_m0_valid,
   input  logic        i_m0_instr,
   input  logic [31:0] i_m0_addr,
   input  logic [31:0] i_m0_wdata,
   input  logic [3:0]  i_m0_wstrb,
   output logic        o_m0_ready,
   output logic [31:0] o_m0_rdata,
   input  logic        i_m1_valid,
   input  logic        i_m1_instr,
   input  logic [31:0] i_m1_addr,
   input  logic [31:0] i_m1_wdata,
   input  logic [3:0]  i_m1_wstrb,
   output logic        o_m1_ready,
   output logic [31:0] o_m1_rdata,
   output logic        o_s_valid,
   output logic        o_s_instr,
   output logic [31:0] o_s_addr,
   output logic [31:0] o_s_wdata,
   output logic [3:0]  o_s_wstrb,
   input  logic        i_s_ready,
   input  logic [31:0] i_s_rdata,
   output logic [1:0]  o_grant,
   output logic        o_bus_err,
   output logic [31:0] o_err_addr,
   output logic        o_err_master
);

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned SW = 4;

   // Timeout fires on the granted cycle where the counter has reached TIMEOUT_CYC-1.
   localparam bit               TO_EN   = (TIMEOUT_CYC != 0);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_prio;        // 0: M0 favoured on a tie, 1: M1 favoured
   logic             w_prio_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [AW-1:0]    r_err_addr;
   logic             r_err_master;
   logic             w_err_load;

   logic             w_g_valid;
   logic [AW-1:0]    w_g_addr;
   logic             w_handshake;
   logic             w_timeout;
   logic             w_done;
   logic [DW-1:0]    w_rdata;

   // State, pointer, timeout counter and error capture registers.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state      <= IDLE;
         r_prio       <= M0_FIRST ? 1'b0 : 1'b1;
         r_cnt        <= '0;
         r_err_addr   <= '0;
         r_err_master <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_prio  <= w_prio_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_err_load) begin
            r_err_addr   <= w_g_addr;
            r_err_master <= (r_state == GNT1);
         end
      end
   end

   // Next-state, arbitration and bus multiplexing.
   always_comb begin
      w_state_nxt = r_state;
      w_prio_nxt  = r_prio;
      w_cnt_nxt   = r_cnt;
      w_err_load  = 1'b0;
      w_g_valid   = 1'b0;
      w_g_addr    = '0;
      w_handshake = 1'b0;
      w_timeout   = 1'b0;
      w_done      = 1'b0;
      w_rdata     = '0;
      o_s_valid   = 1'b0;
      o_s_instr   = 1'b0;
      o_s_addr    = '0;
      o_s_wdata   = '0;
      o_s_wstrb   = '0;
      o_m0_ready  = 1'b0;
      o_m0_rdata  = '0;
      o_m1_ready  = 1'b0;
      o_m1_rdata  = '0;
      o_grant     = 2'b00;
      o_bus_err   = 1'b0;

      case (r_state)
         IDLE: begin
            // Counter is held at zero here so every grant starts a fresh timeout window.
            w_cnt_nxt = '0;
            if (i_m0_valid && (!i_m1_valid || !r_prio)) begin
               w_state_nxt = GNT0;
            end else if (i_m1_valid) begin
               w_state_nxt = GNT1;
            end
         end

         GNT0, GNT1: begin
            if (r_state == GNT0) begin
               o_grant   = 2'b01;
               w_g_valid = i_m0_valid;
               w_g_addr  = i_m0_addr;
               o_s_instr = i_m0_instr;
               o_s_wdata = i_m0_wdata;
               o_s_wstrb = i_m0_wstrb;
            end else begin
               o_grant   = 2'b10;
               w_g_valid = i_m1_valid;
               w_g_addr  = i_m1_addr;
               o_s_instr = i_m1_instr;
               o_s_wdata = i_m1_wdata;
               o_s_wstrb = i_m1_wstrb;
            end
            o_s_valid = w_g_valid;
            o_s_addr  = w_g_addr;

            // A slave completion on the last allowed cycle beats the timeout.
            w_handshake = w_g_valid && i_s_ready;
            w_timeout   = TO_EN && w_g_valid && !i_s_ready && (r_cnt == TO_LAST);
            w_done      = w_handshake || w_timeout;
            w_rdata     = w_timeout ? ERR_RDATA : i_s_rdata;
            o_bus_err   = w_timeout;

            if (r_state == GNT0) begin
               o_m0_ready = w_done;
               o_m0_rdata = w_rdata;
            end else begin
               o_m1_ready = w_done;
               o_m1_rdata = w_rdata;
            end

            if (!w_g_valid) begin
               // Abandoned request: release the bus without moving the pointer.
               w_state_nxt = IDLE;
            end else if (w_done) begin
               w_state_nxt = IDLE;
               w_prio_nxt  = (r_state == GNT0);
               w_err_load  = w_timeout;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end

         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   assign o_err_addr   = r_err_addr;
   assign o_err_master = r_err_master;

endmodule

// File: tb/tb_membus_rr_arbiter.sv
// tb_membus_rr_arbiter: cycle table of bus stimulus with expected arbiter outputs, checked
// through a scoreboard queue, followed by a hand-written back-to-back arbitration sequence.
module tb_membus_rr_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        m0_valid, m0_ready, m1_valid, m1_ready;
   logic [31:0] m0_addr, m1_addr, m0_rdata, m1_rdata;
   logic [3:0]  m1_wstrb;
   logic        s_valid, s_instr, s_ready;
   logic [31:0] s_addr, s_wdata, s_rdata;
   logic [3:0]  s_wstrb;
   logic [1:0]  grant;
   logic        bus_err, err_master;
   logic [31:0] err_addr;

   localparam logic [31:0] M0_WDATA = 32'h0000_0011;
   localparam logic [31:0] M1_WDATA = 32'h0000_00A5;

   always #5 clk = ~clk;

   membus_rr_arbiter #(
      .TIMEOUT_CYC(4),
      .CNT_W      (8),
      .ERR_RDATA  (32'hFFFF_FFFF),
      .M0_FIRST   (1'b1)
   ) dut (
      .i_clk       (clk),
      .i_reset     (reset),
      .i_m0_valid  (m0_valid),
      .i_m0_instr  (1'b1),
      .i_m0_addr   (m0_addr),
      .i_m0_wdata  (M0_WDATA),
      .i_m0_wstrb  (4'b0000),
      .o_m0_ready  (m0_ready),
      .o_m0_rdata  (m0_rdata),
      .i_m1_valid  (m1_valid),
      .i_m1_instr  (1'b0),
      .i_m1_addr   (m1_addr),
      .i_m1_wdata  (M1_WDATA),
      .i_m1_wstrb  (m1_wstrb),
      .o_m1_ready  (m1_ready),
      .o_m1_rdata  (m1_rdata),
      .o_s_valid   (s_valid),
      .o_s_instr   (s_instr),
      .o_s_addr    (s_addr),
      .o_s_wdata   (s_wdata),
      .o_s_wstrb   (s_wstrb),
      .i_s_ready   (s_ready),
      .i_s_rdata   (s_rdata),
      .o_grant     (grant),
      .o_bus_err   (bus_err),
      .o_err_addr  (err_addr),
      .o_err_master(err_master)
   );

   typedef struct {
      logic        rst;
      logic        v0;
      logic [31:0] a0;
      logic        v1;
      logic [31:0] a1;
      logic [3:0]  ws1;
      logic        sr;
      logic [31:0] srd;
      logic [1:0]  grant;
      logic        sv;
      logic [31:0] saddr;
      logic        r0;
      logic [31:0] rd0;
      logic        r1;
      logic [31:0] rd1;
      logic        berr;
      logic [31:0] eaddr;
      logic        emst;
   } vec_t;

   vec_t tbl[$];
   vec_t exp_q[$];
   int   exp_order[$];
   int   n_chk = 0;
   int   n_err = 0;

   function automatic void add(input logic [31:0] rst, v0, a0, v1, a1, ws1, sr, srd,
                               input logic [31:0] g, sv, sa, r0, rd0, r1, rd1, be, ea, em);
      vec_t v;
      v.rst = rst[0];  v.v0 = v0[0];  v.a0 = a0;  v.v1 = v1[0];  v.a1 = a1;
      v.ws1 = ws1[3:0]; v.sr = sr[0]; v.srd = srd;
      v.grant = g[1:0]; v.sv = sv[0]; v.saddr = sa; v.r0 = r0[0]; v.rd0 = rd0;
      v.r1 = r1[0]; v.rd1 = rd1; v.berr = be[0]; v.eaddr = ea; v.emst = em[0];
      tbl.push_back(v);
   endfunction

   task automatic chk(input string nm, input int row, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
      end
   endtask

   task automatic idle_inputs();
      reset = 1'b0; m0_valid = 1'b0; m0_addr = '0; m1_valid = 1'b0; m1_addr = '0;
      m1_wstrb = '0; s_ready = 1'b0; s_rdata = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t        e;
      logic [31:0] exp_swd;
      logic [3:0]  exp_sws;
      bit          done0, done1;
      int          got;

      // rst v0 a0       v1 a1       ws1  sr srd       | grant sv saddr  r0 rd0  r1 rd1  be eaddr   em
      add(1, 0, 0,       0, 0,       0,   0, 0,          0, 0, 0,       0, 0,   0, 0,   0, 0,      0);
      // single M0 read, slave ready combinationally
      add(0, 1, 'h8030,  0, 0,       0,   1, 'h1234,     0, 0, 0,       0, 0,   0, 0,   0, 0,      0);
      add(0, 1, 'h8030,  0, 0,       0,   1, 'h1234,     1, 1, 'h8030,  1, 'h1234, 0, 0, 0, 0,   0);
      add(0, 0, 0,       0, 0,       0,   0, 0,          0, 0, 0,       0, 0,   0, 0,   0, 0,      0);
      // fresh reset, then simultaneous requests alternate
      add(1, 0, 0,       0, 0,       0,   0, 0,          0, 0, 0,       0, 0,   0, 0,   0, 0,      0);
      add(0, 1, 'h100,   1, 'h200,   0,   0, 0,          0, 0, 0,       0, 0,   0, 0,   0, 0,      0);
      add(0, 1, 'h100,   1, 'h200,   0,   1, 'hAAAA,     1, 1, 'h100,   1, 'hAAAA, 0, 0, 0, 0,   0);
      add(0, 1, 'h104,   1, 'h200,   0,   0, 0,          0, 0, 0,       0, 0,   0, 0,   0, 0,      0);
      add(0, 1, 'h104,   1, 'h200,   0,   1, 'hBBBB,     2, 1, 'h200,   0, 0,   1, 'hBBBB, 0, 0, 0);
      add(0, 1, 'h104,   1, 'h204,   0,   0, 0,          0, 0, 0,       0, 0,   0, 0,   0, 0,      0);
      add(0, 1, 'h104,   1, 'h204,   0,   1, 'hCCCC,     1, 1, 'h104,   1, 'hCCCC, 0, 0, 0, 0,   0);
      add(0, 0, 0,       1, 'h204,   0,   0, 0,          0, 0, 0,       0, 0,   0, 0,   0, 0,      0);
      add(0, 0, 0,       1, 'h204,   0,   1, 'hDDDD,     2, 1, 'h204,   0, 0,   1, 'hDDDD, 0, 0, 0);
      add(0, 0, 0,       0, 0,       0,   0, 0,          0, 0, 0,       0, 0,   0, 0,   0, 0,      0);
      // M1 write, slave answers on the last cycle before timeout; M0 waits
      add(0, 0, 0,       1, 'h8070,  'hF, 0, 0,          0, 0, 0,       0, 0,   0, 0,   0, 0,      0);
      add(0, 1, 'h300,   1, 'h8070,  'hF, 0, 0,          2, 1, 'h8070,  0, 0,   0, 0,   0, 0,      0);
      add(0, 1, 'h300,   1, 'h8070,  'hF, 0, 0,          2, 1, 'h8070,  0, 0,   0, 0,   0, 0,      0);
      add(0, 1, 'h300,   1, 'h8070,  'hF, 0, 0,          2, 1, 'h8070,  0, 0,   0, 0,   0, 0,      0);
      add(0, 1, 'h300,   1, 'h8070,  'hF, 1, 0,          2, 1, 'h8070,  0, 0,   1, 0,   0, 0,      0);
      add(0, 1, 'h300,   0, 0,       0,   0, 0,          0, 0, 0,       0, 0,   0, 0,   0, 0,      0);
      add(0, 1, 'h300,   0, 0,       0,   1, 'h5555,     1, 1, 'h300,   1, 'h5555, 0, 0, 0, 0,   0);
      add(0, 0, 0,       0, 0,       0,   0, 0,          0, 0, 0,       0, 0,   0, 0,   0, 0,      0);
      // M1 read to a dead slave: timeout on the 4th granted cycle
      add(0, 0, 0,       1, 'h8090,  0,   0, 0,          0, 0, 0,       0, 0,   0, 0,   0, 0,      0);
      add(0, 0, 0,       1, 'h8090,  0,   0, 0,          2, 1, 'h8090,  0, 0,   0, 0,   0, 0,      0);
      add(0, 0, 0,       1, 'h8090,  0,   0, 0,          2, 1, 'h8090,  0, 0,   0, 0,   0, 0,      0);
      add(0, 0, 0,       1, 'h8090,  0,   0, 0,          2, 1, 'h8090,  0, 0,   0, 0,   0, 0,      0);
      add(0, 0, 0,       1, 'h8090,  0,   0, 0,          2, 1, 'h8090,  0, 0,   1, 'hFFFF_FFFF, 1, 0, 0);
      add(0, 0, 0,       0, 0,       0,   0, 0,          0, 0, 0,       0, 0,   0, 0,   0, 'h8090, 1);
      // reset while M0 is granted and stalled
      add(0, 1, 'h400,   0, 0,       0,   0, 0,          0, 0, 0,       0, 0,   0, 0,   0, 'h8090, 1);
      add(0, 1, 'h400,   0, 0,       0,   0, 0,          1, 1, 'h400,   0, 0,   0, 0,   0, 'h8090, 1);
      add(1, 1, 'h400,   0, 0,       0,   0, 0,          1, 1, 'h400,   0, 0,   0, 0,   0, 'h8090, 1);
      add(0, 1, 'h400,   0, 0,       0,   0, 0,          0, 0, 0,       0, 0,   0, 0,   0, 0,      0);
      add(0, 1, 'h400,   0, 0,       0,   1, 'h7777,     1, 1, 'h400,   1, 'h7777, 0, 0, 0, 0,   0);
      add(0, 0, 0,       0, 0,       0,   0, 0,          0, 0, 0,       0, 0,   0, 0,   0, 0,      0);
      // M1 completes (pointer -> M0), then M0 abandons; pointer must still favour M0
      add(0, 0, 0,       1, 'h500,   0,   0, 0,          0, 0, 0,       0, 0,   0, 0,   0, 0,      0);
      add(0, 0, 0,       1, 'h500,   0,   1, 'h1,        2, 1, 'h500,   0, 0,   1, 'h1, 0, 0,      0);
      add(0, 1, 'h600,   0, 0,       0,   0, 0,          0, 0, 0,       0, 0,   0, 0,   0, 0,      0);
      add(0, 1, 'h600,   0, 0,       0,   0, 0,          1, 1, 'h600,   0, 0,   0, 0,   0, 0,      0);
      add(0, 0, 'h600,   0, 0,       0,   0, 0,          1, 0, 'h600,   0, 0,   0, 0,   0, 0,      0);
      add(0, 1, 'h700,   1, 'h800,   0,   0, 0,          0, 0, 0,       0, 0,   0, 0,   0, 0,      0);
      add(0, 1, 'h700,   1, 'h800,   0,   1, 'h2,        1, 1, 'h700,   1, 'h2, 0, 0,   0, 0,      0);
      add(0, 0, 0,       1, 'h800,   0,   0, 0,          0, 0, 0,       0, 0,   0, 0,   0, 0,      0);
      add(0, 0, 0,       1, 'h800,   0,   1, 'h3,        2, 1, 'h800,   0, 0,   1, 'h3, 0, 0,      0);
      // M0 timeout records err_master = 0
      add(0, 1, 'h900,   0, 0,       0,   0, 0,          0, 0, 0,       0, 0,   0, 0,   0, 0,      0);
      add(0, 1, 'h900,   0, 0,       0,   0, 0,          1, 1, 'h900,   0, 0,   0, 0,   0, 0,      0);
      add(0, 1, 'h900,   0, 0,       0,   0, 0,          1, 1, 'h900,   0, 0,   0, 0,   0, 0,      0);
      add(0, 1, 'h900,   0, 0,       0,   0, 0,          1, 1, 'h900,   0, 0,   0, 0,   0, 0,      0);
      add(0, 1, 'h900,   0, 0,       0,   0, 0,          1, 1, 'h900,   1, 'hFFFF_FFFF, 0, 0, 1, 0, 0);
      add(0, 0, 0,       0, 0,       0,   0, 0,          0, 0, 0,       0, 0,   0, 0,   0, 'h900,  0);

      idle_inputs();
      reset = 1'b1;
      @(posedge clk);

      foreach (tbl[i]) begin
         @(posedge clk);
         #1;
         reset = tbl[i].rst;  m0_valid = tbl[i].v0;  m0_addr = tbl[i].a0;
         m1_valid = tbl[i].v1; m1_addr = tbl[i].a1;  m1_wstrb = tbl[i].ws1;
         s_ready = tbl[i].sr;  s_rdata = tbl[i].srd;
         exp_q.push_back(tbl[i]);
         @(negedge clk);
         e = exp_q.pop_front();
         exp_swd = (e.grant == 2'b01) ? M0_WDATA : (e.grant == 2'b10) ? M1_WDATA : 32'h0;
         exp_sws = (e.grant == 2'b10) ? e.ws1 : 4'h0;
         chk("grant",      i, 32'(grant),      32'(e.grant));
         chk("s_valid",    i, 32'(s_valid),    32'(e.sv));
         chk("s_addr",     i, s_addr,          e.saddr);
         chk("s_wdata",    i, s_wdata,         exp_swd);
         chk("s_wstrb",    i, 32'(s_wstrb),    32'(exp_sws));
         chk("s_instr",    i, 32'(s_instr),    32'(e.grant == 2'b01));
         chk("m0_ready",   i, 32'(m0_ready),   32'(e.r0));
         chk("m0_rdata",   i, m0_rdata,        e.rd0);
         chk("m1_ready",   i, 32'(m1_ready),   32'(e.r1));
         chk("m1_rdata",   i, m1_rdata,        e.rd1);
         chk("bus_err",    i, 32'(bus_err),    32'(e.berr));
         chk("err_addr",   i, err_addr,        e.eaddr);
         chk("err_master", i, 32'(err_master), 32'(e.emst));
      end

      // Both masters request back to back; the pointer currently favours M1.
      exp_order.push_back(1);
      exp_order.push_back(0);
      done0 = 1'b0;
      done1 = 1'b0;
      for (int cyc = 0; cyc < 10 && !(done0 && done1); cyc++) begin
         @(posedge clk);
         #1;
         idle_inputs();
         m0_valid = !done0; m0_addr = 32'h0000_0A00;
         m1_valid = !done1; m1_addr = 32'h0000_0B00;
         s_ready  = 1'b1;   s_rdata = 32'h0000_0099;
         @(negedge clk);
         chk("one_hot_ready", cyc, 32'(m0_ready & m1_ready), 32'h0);
         if (m1_ready || m0_ready) begin
            got = m1_ready ? 1 : 0;
            if (exp_order.size() == 0) begin
               chk("extra_ready", cyc, 32'(got), 32'hFFFF_FFFF);
            end else begin
               chk("serve_order", cyc, 32'(got), 32'(exp_order.pop_front()));
               chk("serve_addr", cyc, s_addr, got == 1 ? 32'h0000_0B00 : 32'h0000_0A00);
            end
            if (m1_ready) done1 = 1'b1;
            if (m0_ready) done0 = 1'b0 | 1'b1;
         end
      end
      chk("serve_budget", 0, 32'(done0 && done1), 32'h1);

      @(posedge clk);
      #1;
      idle_inputs();
      @(negedge clk);
      chk("final_grant", 0, 32'(grant), 32'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
